nested_loop_counter: RTL and testbench

//   Three-level nested loop counter (inner/mid/outer) with runtime-programmable limits.

---
 rtl/nested_loop_counter.sv | 94 +++++++++
 tb/tb_nested_loop_counter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nested_loop_counter.sv
// Three-level nested loop counter (inner/mid/outer) with runtime limits,
// advance enable and a start/busy/done handshake for conv address sequencing.
module nested_loop_counter #(
    parameter int unsigned W0 = 7,
    parameter int unsigned W1 = 7,
    parameter int unsigned W2 = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          en,
    input  logic [W0-1:0] lim0,
    input  logic [W1-1:0] lim1,
    input  logic [W2-1:0] lim2,
    output logic [W0-1:0] cnt0,
    output logic [W1-1:0] cnt1,
    output logic [W2-1:0] cnt2,
    output logic          busy,
    output logic          wrap0,
    output logic          wrap1,
    output logic          done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [W0-1:0] l0;
    logic [W1-1:0] l1;
    logic [W2-1:0] l2;

    // Carry chain: each level advances only when every inner level is at its limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            l0    <= '0;
            l1    <= '0;
            l2    <= '0;
            cnt0  <= '0;
            cnt1  <= '0;
            cnt2  <= '0;
            busy  <= 1'b0;
            wrap0 <= 1'b0;
            wrap1 <= 1'b0;
            done  <= 1'b0;
        end else begin
            wrap0 <= 1'b0;
            wrap1 <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        l0    <= lim0;
                        l1    <= lim1;
                        l2    <= lim2;
                        cnt0  <= '0;
                        cnt1  <= '0;
                        cnt2  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (cnt0 != l0) begin
                            cnt0 <= cnt0 + W0'(1);
                        end else begin
                            cnt0  <= '0;
                            wrap0 <= 1'b1;
                            if (cnt1 != l1) begin
                                cnt1 <= cnt1 + W1'(1);
                            end else begin
                                cnt1  <= '0;
                                wrap1 <= 1'b1;
                                if (cnt2 != l2) begin
                                    cnt2 <= cnt2 + W2'(1);
                                end else begin
                                    cnt2  <= '0;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nested_loop_counter.sv
// Directed-vector bench for nested_loop_counter; each observation packs
// {cnt2,cnt1,cnt0,busy,wrap0,wrap1,done} and compares against hand values.
module tb_nested_loop_counter;

    logic       clk = 1'b0;
    logic       reset, start, en;
    logic [6:0] lim0, lim1, lim2;
    logic [6:0] cnt0, cnt1, cnt2;
    logic       busy, wrap0, wrap1, done;

    int vectors = 0;
    int miscompares = 0;

    nested_loop_counter #(.W0(7), .W1(7), .W2(7)) dut (
        .clk(clk), .reset(reset), .start(start), .en(en),
        .lim0(lim0), .lim1(lim1), .lim2(lim2),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2),
        .busy(busy), .wrap0(wrap0), .wrap1(wrap1), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] obs();
        return {cnt2, cnt1, cnt0, busy, wrap0, wrap1, done};
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
        start = 1'b1; lim0 = a; lim1 = b; lim2 = c;
        tick();
        start = 1'b0; lim0 = 7'h55; lim1 = 7'h2a; lim2 = 7'h7f;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; en = 1'b0; lim0 = '0; lim1 = '0; lim2 = '0;
        tick(); tick();
        reset = 1'b0;
        vectors++;
        if (obs() !== 25'd0) begin
            miscompares++;
            $display("FAIL reset: got %h want %h", obs(), 25'd0);
        end
    endtask

    task automatic test_wrap80();
        launch(7'd79, 7'd0, 7'd0);
        en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            vectors++;
            if (obs() !== {7'd0, 7'd0, 7'(i), 1'b1, 1'b0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL wrap80 step %0d: got %h want %h", i, obs(),
                         {7'd0, 7'd0, 7'(i), 1'b1, 1'b0, 1'b0, 1'b0});
            end
            tick();
        end
        vectors++;
        if (obs() !== {7'd0, 7'd0, 7'd0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap80 end: got %h want %h", obs(),
                     {7'd0, 7'd0, 7'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_sequence();
        int n0 = 0, n1 = 0, nd = 0;
        launch(7'd2, 7'd1, 7'd1);
        en = 1'b1;
        for (int c2 = 0; c2 < 2; c2++)
            for (int c1 = 0; c1 < 2; c1++)
                for (int c0 = 0; c0 < 3; c0++) begin
                    vectors++;
                    if ({cnt2, cnt1, cnt0, busy} !== {7'(c2), 7'(c1), 7'(c0), 1'b1}) begin
                        miscompares++;
                        $display("FAIL seq index: got %0d,%0d,%0d busy %b want %0d,%0d,%0d busy 1",
                                 cnt0, cnt1, cnt2, busy, c0, c1, c2);
                    end
                    tick();
                    n0 += int'(wrap0); n1 += int'(wrap1); nd += int'(done);
                end
        en = 1'b0;
        tick();
        n0 += int'(wrap0); n1 += int'(wrap1); nd += int'(done);
        vectors++;
        if (n0 != 4 || n1 != 2 || nd != 1) begin
            miscompares++;
            $display("FAIL seq pulses: got w0=%0d w1=%0d d=%0d want 4 2 1", n0, n1, nd);
        end
    endtask

    task automatic test_en_toggle();
        int         exp_cnt[8]  = '{1, 1, 2, 2, 3, 3, 0, 0};
        logic [7:0] exp_done    = 8'b0100_0000;
        logic [7:0] exp_busy    = 8'b0011_1111;
        launch(7'd3, 7'd0, 7'd0);
        for (int k = 0; k < 8; k++) begin
            en = (k % 2 == 0);
            tick();
            vectors++;
            if ({cnt0, busy, wrap0, done} !== {7'(exp_cnt[k]), exp_busy[k], exp_done[k], exp_done[k]}) begin
                miscompares++;
                $display("FAIL en_toggle k=%0d: got cnt0=%0d busy=%b w0=%b done=%b want %0d %b %b %b",
                         k, cnt0, busy, wrap0, done, exp_cnt[k], exp_busy[k], exp_done[k], exp_done[k]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_zero();
        launch(7'd0, 7'd0, 7'd0);
        en = 1'b1;
        tick();
        vectors++;
        if (obs() !== {21'd0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL zero done: got %h want %h", obs(), {21'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        end
        tick();
        vectors++;
        if (obs() !== 25'd0) begin
            miscompares++;
            $display("FAIL zero idle: got %h want %h", obs(), 25'd0);
        end
        en = 1'b0;
    endtask

    task automatic test_start_ignored();
        launch(7'd5, 7'd0, 7'd0);
        en = 1'b1;
        tick();
        start = 1'b1; lim0 = 7'd1;
        tick();
        start = 1'b0;
        vectors++;
        if ({cnt0, busy} !== {7'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL start_ign mid: got cnt0=%0d busy=%b want 2 1", cnt0, busy);
        end
        tick(); tick(); tick();
        vectors++;
        if ({cnt0, busy, wrap0, done} !== {7'd5, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL start_ign pre: got cnt0=%0d busy=%b w0=%b d=%b want 5 1 0 0",
                     cnt0, busy, wrap0, done);
        end
        tick();
        vectors++;
        if ({cnt0, busy, wrap0, done} !== {7'd0, 1'b0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL start_ign wrap: got cnt0=%0d busy=%b w0=%b d=%b want 0 0 1 1",
                     cnt0, busy, wrap0, done);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        launch(7'd1, 7'd1, 7'd1);
        en = 1'b1;
        tick(); tick(); tick();
        vectors++;
        if (obs() !== {7'd0, 7'd1, 7'd1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid pre: got %h want %h", obs(), {7'd0, 7'd1, 7'd1, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b0;
        vectors++;
        if (obs() !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got %h want %h", obs(), 25'd0);
        end
        launch(7'd1, 7'd0, 7'd0);
        en = 1'b1;
        tick(); tick();
        vectors++;
        if (obs() !== {21'd0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_mid restart: got %h want %h", obs(), {21'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        launch(7'd1, 7'd0, 7'd0);
        en = 1'b1;
        tick();
        start = 1'b1; lim0 = 7'd2; lim1 = 7'd0; lim2 = 7'd0;
        tick();
        vectors++;
        if ({busy, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b terminal: got busy=%b done=%b want 0 1", busy, done);
        end
        tick();
        start = 1'b0;
        vectors++;
        if ({cnt0, busy, done} !== {7'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b accept: got cnt0=%0d busy=%b done=%b want 0 1 0", cnt0, busy, done);
        end
        tick(); tick();
        vectors++;
        if ({cnt0, done} !== {7'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b mid: got cnt0=%0d done=%b want 2 0", cnt0, done);
        end
        tick();
        vectors++;
        if ({busy, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b end: got busy=%b done=%b want 0 1", busy, done);
        end
        en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_wrap80();
        test_sequence();
        test_en_toggle();
        test_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
